// File: rtl/cu_fsm.sv
// Multicycle sequencing control unit for the OTTER RV32I core: FETCH/EXEC/WB/INTR timing of all writes.
// Optional memory handshake stalls are enabled by defining CU_FSM_MEM_READY_EN.
module cu_fsm (
    input  logic       CLK,
    input  logic       RST,
    input  logic       INTR,
    input  logic [6:0] IR_OPCODE,
    input  logic [2:0] IR_FUNCT,
    input  logic       MEM_READY,
    output logic       PC_WRITE,
    output logic       REG_WRITE,
    output logic       MEM_WE2,
    output logic       MEM_RDEN1,
    output logic       MEM_RDEN2,
    output logic       CSR_WE,
    output logic       INT_TAKEN,
    output logic       MRET_EXEC,
    output logic [2:0] CU_STATE
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    state_t state_q, state_d;
    logic   mem_ready_s;
    logic   done_s;
    logic   pc_write_s, reg_write_s, mem_we2_s, mem_rden1_s;
    logic   mem_rden2_s, csr_we_s, int_taken_s, mret_exec_s;

`ifdef CU_FSM_MEM_READY_EN
    assign mem_ready_s = MEM_READY;
`else
    // Handshake forced to ready; the port is still read so it is not left dangling.
    assign mem_ready_s = MEM_READY | 1'b1;
`endif

    // State register with asynchronous reset to INIT.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Mealy enable decode.
    always_comb begin
        state_d     = state_q;
        done_s      = 1'b0;
        pc_write_s  = 1'b0;
        reg_write_s = 1'b0;
        mem_we2_s   = 1'b0;
        mem_rden1_s = 1'b0;
        mem_rden2_s = 1'b0;
        csr_we_s    = 1'b0;
        int_taken_s = 1'b0;
        mret_exec_s = 1'b0;
        case (state_q)
            ST_INIT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_rden1_s = 1'b1;
                if (mem_ready_s) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                case (IR_OPCODE)
                    OPC_LOAD: begin
                        mem_rden2_s = 1'b1;
                        if (mem_ready_s) begin
                            state_d = ST_WB;
                        end else begin
                            state_d = ST_EXEC;
                        end
                    end
                    OPC_STORE: begin
                        mem_we2_s = 1'b1;
                        if (mem_ready_s) begin
                            pc_write_s = 1'b1;
                            done_s     = 1'b1;
                        end else begin
                            done_s     = 1'b0;
                        end
                    end
                    OPC_BRANCH: begin
                        pc_write_s = 1'b1;
                        done_s     = 1'b1;
                    end
                    OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OPIMM, OPC_OP: begin
                        pc_write_s  = 1'b1;
                        reg_write_s = 1'b1;
                        done_s      = 1'b1;
                    end
                    OPC_SYSTEM: begin
                        pc_write_s = 1'b1;
                        done_s     = 1'b1;
                        case (IR_FUNCT)
                            3'b001: begin
                                reg_write_s = 1'b1;
                                csr_we_s    = 1'b1;
                            end
                            3'b000: begin
                                mret_exec_s = 1'b1;
                            end
                            default: begin
                                csr_we_s = 1'b0;
                            end
                        endcase
                    end
                    default: begin
                        pc_write_s = 1'b1;
                        done_s     = 1'b1;
                    end
                endcase
                // Interrupts are only sampled when the instruction actually completes here.
                if (done_s) begin
                    state_d = INTR ? ST_INTR : ST_FETCH;
                end else begin
                    done_s = 1'b0;
                end
            end
            ST_WB: begin
                reg_write_s = 1'b1;
                pc_write_s  = 1'b1;
                state_d     = INTR ? ST_INTR : ST_FETCH;
            end
            ST_INTR: begin
                int_taken_s = 1'b1;
                pc_write_s  = 1'b1;
                state_d     = ST_FETCH;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign PC_WRITE  = pc_write_s  & ~RST;
    assign REG_WRITE = reg_write_s & ~RST;
    assign MEM_WE2   = mem_we2_s   & ~RST;
    assign MEM_RDEN1 = mem_rden1_s & ~RST;
    assign MEM_RDEN2 = mem_rden2_s & ~RST;
    assign CSR_WE    = csr_we_s    & ~RST;
    assign INT_TAKEN = int_taken_s & ~RST;
    assign MRET_EXEC = mret_exec_s & ~RST;
    assign CU_STATE  = state_q;

endmodule

// File: tb/tb_cu_fsm.sv
// Directed self-checking bench for cu_fsm; state and all enables are checked on the falling clock edge.
module tb_cu_fsm;

    logic       CLK;
    logic       RST;
    logic       INTR;
    logic [6:0] IR_OPCODE;
    logic [2:0] IR_FUNCT;
    logic       MEM_READY;
    logic       PC_WRITE, REG_WRITE, MEM_WE2, MEM_RDEN1, MEM_RDEN2;
    logic       CSR_WE, INT_TAKEN, MRET_EXEC;
    logic [2:0] CU_STATE;
    logic [7:0] outs_s;

    int n_cmp = 0;
    int n_bad = 0;

    // Output vector order: PC_WRITE REG_WRITE MEM_WE2 MEM_RDEN1 MEM_RDEN2 CSR_WE INT_TAKEN MRET_EXEC
    localparam logic [7:0] O_NONE  = 8'b0000_0000;
    localparam logic [7:0] O_FETCH = 8'b0001_0000;
    localparam logic [7:0] O_ALU   = 8'b1100_0000;
    localparam logic [7:0] O_LOAD  = 8'b0000_1000;
    localparam logic [7:0] O_STORE = 8'b1010_0000;
    localparam logic [7:0] O_STALL = 8'b0010_0000;
    localparam logic [7:0] O_PC    = 8'b1000_0000;
    localparam logic [7:0] O_CSR   = 8'b1100_0100;
    localparam logic [7:0] O_MRET  = 8'b1000_0001;
    localparam logic [7:0] O_WB    = 8'b1100_0000;
    localparam logic [7:0] O_INT   = 8'b1000_0010;

    cu_fsm dut (
        .CLK       (CLK),
        .RST       (RST),
        .INTR      (INTR),
        .IR_OPCODE (IR_OPCODE),
        .IR_FUNCT  (IR_FUNCT),
        .MEM_READY (MEM_READY),
        .PC_WRITE  (PC_WRITE),
        .REG_WRITE (REG_WRITE),
        .MEM_WE2   (MEM_WE2),
        .MEM_RDEN1 (MEM_RDEN1),
        .MEM_RDEN2 (MEM_RDEN2),
        .CSR_WE    (CSR_WE),
        .INT_TAKEN (INT_TAKEN),
        .MRET_EXEC (MRET_EXEC),
        .CU_STATE  (CU_STATE)
    );

    assign outs_s = {PC_WRITE, REG_WRITE, MEM_WE2, MEM_RDEN1, MEM_RDEN2, CSR_WE, INT_TAKEN, MRET_EXEC};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [2:0] st, input logic [7:0] o);
        n_cmp++;
        assert ({CU_STATE, outs_s} === {st, o})
        else begin
            n_bad++;
            $error("FAIL %s: observed state=%0d outs=%b, expected state=%0d outs=%b",
                   tag, CU_STATE, outs_s, st, o);
        end
    endtask

    task automatic nxt();
        @(negedge CLK);
    endtask

    initial begin
        RST       = 1'b1;
        INTR      = 1'b0;
        IR_OPCODE = 7'b0010011;
        IR_FUNCT  = 3'b000;
        MEM_READY = 1'b1;

        // Reset and release: INIT held one cycle, then FETCH.
        nxt(); chk("rst_hold", 3'd0, O_NONE);
        @(posedge CLK); #1 RST = 1'b0;
        nxt(); chk("init_after_rst", 3'd0, O_NONE);
        nxt(); chk("first_fetch", 3'd1, O_FETCH);

        // ADDI: 1,2,1 with PC/REG write for one cycle.
        nxt(); chk("addi_exec", 3'd2, O_ALU);
        nxt(); chk("addi_back_fetch", 3'd1, O_FETCH);

        // Reset asserted mid-EXEC acts without a clock edge.
        nxt(); chk("addi2_exec", 3'd2, O_ALU);
        #1 RST = 1'b1;
        #1 chk("rst_async_mid_exec", 3'd0, O_NONE);
        @(posedge CLK); #1 RST = 1'b0;
        nxt(); chk("init_after_rst2", 3'd0, O_NONE);
        nxt(); chk("fetch_after_rst2", 3'd1, O_FETCH);

        // LW with INTR raised during EXEC: 1,2,3,4,1.
        IR_OPCODE = 7'b0000011;
        nxt(); chk("lw_exec", 3'd2, O_LOAD);
        INTR = 1'b1;
        nxt(); chk("lw_wb_no_int_in_exec", 3'd3, O_WB);
        nxt(); chk("lw_int_taken", 3'd4, O_INT);
        INTR = 1'b0;
        IR_OPCODE = 7'b1110011;
        IR_FUNCT  = 3'b001;
        nxt(); chk("fetch_after_int", 3'd1, O_FETCH);

        // SYSTEM: CSRRW, MRET, other funct.
        nxt(); chk("csrrw_exec", 3'd2, O_CSR);
        IR_FUNCT = 3'b000;
        nxt(); chk("fetch_before_mret", 3'd1, O_FETCH);
        nxt(); chk("mret_exec", 3'd2, O_MRET);
        IR_FUNCT = 3'b010;
        #1 chk("system_other_funct", 3'd2, O_PC);
        nxt(); chk("fetch_after_system", 3'd1, O_FETCH);

        // INTR held high: 2,4,1,2,4.
        IR_OPCODE = 7'b0010011;
        INTR = 1'b1;
        nxt(); chk("hold_int_exec1", 3'd2, O_ALU);
        nxt(); chk("hold_int_taken1", 3'd4, O_INT);
        nxt(); chk("hold_int_fetch", 3'd1, O_FETCH);
        nxt(); chk("hold_int_exec2", 3'd2, O_ALU);
        nxt(); chk("hold_int_taken2", 3'd4, O_INT);
        INTR = 1'b0;
        IR_OPCODE = 7'b1100011;
        nxt(); chk("fetch_after_hold", 3'd1, O_FETCH);

        // Branch, unknown opcode and LUI decoded within one EXEC cycle.
        nxt(); chk("branch_exec", 3'd2, O_PC);
        IR_OPCODE = 7'b1111111;
        #1 chk("unknown_opcode_nop", 3'd2, O_PC);
        IR_OPCODE = 7'b0110111;
        #1 chk("lui_exec", 3'd2, O_ALU);
        IR_OPCODE = 7'b0100011;
        nxt(); chk("fetch_before_sw", 3'd1, O_FETCH);

        // SW with MEM_READY low for three EXEC cycles.
        @(posedge CLK); #1 MEM_READY = 1'b0;
`ifdef CU_FSM_MEM_READY_EN
        @(negedge CLK); chk("sw_stall1", 3'd2, O_STALL);
        nxt(); chk("sw_stall2", 3'd2, O_STALL);
        nxt(); chk("sw_stall3", 3'd2, O_STALL);
        MEM_READY = 1'b1;
        nxt(); chk("sw_done", 3'd2, O_STORE);
`else
        @(negedge CLK); chk("sw_single_exec", 3'd2, O_STORE);
`endif
        nxt(); chk("fetch_after_sw", 3'd1, O_FETCH);
        MEM_READY = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
